ldpc_iter_ctrl: RTL and testbench

LDPC_ITER_CTRL -- requirements
Module: ldpc_iter_ctrl

---
 rtl/ldpc_iter_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ldpc_iter_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_iter_ctrl.sv
// LDPC decoder iteration controller: sequences init, check-node / variable-node passes and output.
// Optional per-phase watchdog is built when LDPC_ITER_WDOG_EN is defined.
module ldpc_iter_ctrl #(
    parameter int ITER_W     = 8,
    parameter int SYN_W      = 18,
    parameter int RATE_W     = 2,
    parameter int WDOG_LIMIT = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ITER_W-1:0] max_iter,
    input  logic [RATE_W-1:0] rate,
    input  logic              init_done,
    input  logic              cnp_done,
    input  logic              vnp_done,
    input  logic              dec_done,
    input  logic              syn_vld,
    input  logic [SYN_W-1:0]  syn_word,
    output logic              cnp_start,
    output logic              vnp_start,
    output logic              dec_start,
    output logic [RATE_W-1:0] rate_q,
    output logic [ITER_W-1:0] iter_num,
    output logic              busy,
    output logic              converged,
    output logic              failed,
    output logic              timeout
);

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        INIT = 5'b00010,
        CNP  = 5'b00100,
        VNP  = 5'b01000,
        OUT  = 5'b10000
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ITER_W-1:0] max_q;
    logic              sf;
    logic              syn_bad;
    logic              sf_eff;
    logic              wdog_expire;
    logic              accept;
    logic              cnp_go;
    logic              vnp_go;
    logic              dec_go;
    logic              set_conv;
    logic              set_fail;
    logic              iter_inc;
    logic              timeout_nxt;

    // A syndrome beat coincident with cnp_done still counts for this pass.
    assign syn_bad = syn_vld && (|syn_word);
    assign sf_eff  = sf || syn_bad;
    assign busy    = (state != IDLE);

`ifdef LDPC_ITER_WDOG_EN
    localparam int WDOG_CW = $clog2(WDOG_LIMIT + 1);
    logic [WDOG_CW-1:0] wdog_cnt;

    // Counter restarts on every state change, so each phase gets its own budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt <= '0;
        end else if (state_nxt != state) begin
            wdog_cnt <= '0;
        end else if (state != IDLE) begin
            wdog_cnt <= wdog_cnt + WDOG_CW'(1);
        end
    end

    assign wdog_expire = (state != IDLE) && (wdog_cnt == WDOG_CW'(WDOG_LIMIT - 1));
`else
    // No counter in this build; the limit only matters when the watchdog exists.
    assign wdog_expire = 1'b0 & (WDOG_LIMIT == 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        cnp_go      = 1'b0;
        vnp_go      = 1'b0;
        dec_go      = 1'b0;
        set_conv    = 1'b0;
        set_fail    = 1'b0;
        iter_inc    = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt = INIT;
                accept    = 1'b1;
            end
            INIT: if (init_done) begin
                state_nxt = CNP;
                cnp_go    = 1'b1;
            end
            CNP: if (cnp_done) begin
                if (!sf_eff) begin
                    state_nxt = OUT;
                    dec_go    = 1'b1;
                    set_conv  = 1'b1;
                end else if (iter_num == max_q) begin
                    state_nxt = OUT;
                    dec_go    = 1'b1;
                    set_fail  = 1'b1;
                end else begin
                    state_nxt = VNP;
                    vnp_go    = 1'b1;
                    iter_inc  = 1'b1;
                end
            end
            VNP: if (vnp_done) begin
                state_nxt = CNP;
                cnp_go    = 1'b1;
            end
            OUT: if (dec_done) begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (wdog_expire) begin
            state_nxt   = IDLE;
            cnp_go      = 1'b0;
            vnp_go      = 1'b0;
            dec_go      = 1'b0;
            set_conv    = 1'b0;
            iter_inc    = 1'b0;
            set_fail    = 1'b1;
            timeout_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnp_start <= 1'b0;
            vnp_start <= 1'b0;
            dec_start <= 1'b0;
            timeout   <= 1'b0;
            rate_q    <= '0;
            max_q     <= '0;
            iter_num  <= '0;
            converged <= 1'b0;
            failed    <= 1'b0;
            sf        <= 1'b0;
        end else begin
            cnp_start <= cnp_go;
            vnp_start <= vnp_go;
            dec_start <= dec_go;
            timeout   <= timeout_nxt;
            if (accept) begin
                rate_q    <= rate;
                max_q     <= max_iter;
                iter_num  <= '0;
                converged <= 1'b0;
                failed    <= 1'b0;
            end
            if (set_conv) converged <= 1'b1;
            if (set_fail) failed <= 1'b1;
            // Increment only happens below max_q, so iter_num cannot wrap.
            if (iter_inc) iter_num <= iter_num + ITER_W'(1);
            if (cnp_go) begin
                sf <= 1'b0;
            end else if (state == CNP && syn_bad) begin
                sf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed bench for ldpc_iter_ctrl: drivers push expected decode results, a monitor checks them at busy fall.
module tb_ldpc_iter_ctrl;
    localparam int ITER_W = 8;
    localparam int SYN_W  = 18;
    localparam int RATE_W = 2;
`ifdef LDPC_ITER_WDOG_EN
    localparam int WDOG = 100;
`else
    localparam int WDOG = 65535;
`endif
    localparam int WAIT_MAX = 40;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ITER_W-1:0] max_iter = '0;
    logic [RATE_W-1:0] rate = '0;
    logic              init_done = 1'b0;
    logic              cnp_done = 1'b0;
    logic              vnp_done = 1'b0;
    logic              dec_done = 1'b0;
    logic              syn_vld = 1'b0;
    logic [SYN_W-1:0]  syn_word = '0;
    logic              cnp_start, vnp_start, dec_start;
    logic [RATE_W-1:0] rate_q;
    logic [ITER_W-1:0] iter_num;
    logic              busy, converged, failed, timeout;

    ldpc_iter_ctrl #(
        .ITER_W(ITER_W), .SYN_W(SYN_W), .RATE_W(RATE_W), .WDOG_LIMIT(WDOG)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .max_iter(max_iter), .rate(rate),
        .init_done(init_done), .cnp_done(cnp_done), .vnp_done(vnp_done), .dec_done(dec_done),
        .syn_vld(syn_vld), .syn_word(syn_word),
        .cnp_start(cnp_start), .vnp_start(vnp_start), .dec_start(dec_start),
        .rate_q(rate_q), .iter_num(iter_num), .busy(busy),
        .converged(converged), .failed(failed), .timeout(timeout)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000 time units");
        $fatal(1, "bench timeout");
    end

    int tests = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // result word: {0, timeout, converged, failed, rate_q, iter_num, #cnp_start, #vnp_start, #dec_start}
    function automatic logic [31:0] pack(bit to, bit conv, bit fail, logic [1:0] r,
                                         logic [7:0] it, int nc, int nv, int nd);
        return {1'b0, to, conv, fail, r, it, 6'(nc), 6'(nv), 6'(nd)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check(name, {15'd0, cnp_start, vnp_start, dec_start, busy, timeout, converged, failed,
                     rate_q, iter_num}, 32'd0);
    endtask

    // scoreboard monitor
    int c_cnp = 0, c_vnp = 0, c_dec = 0;
    bit to_seen = 0, prev_busy = 0;

    always @(negedge clk) begin
        if (reset) begin
            c_cnp = 0; c_vnp = 0; c_dec = 0; to_seen = 0; prev_busy = 0;
        end else begin
            if (cnp_start) c_cnp++;
            if (vnp_start) c_vnp++;
            if (dec_start) c_dec++;
            if (timeout) to_seen = 1;
            if (int'(cnp_start) + int'(vnp_start) + int'(dec_start) + int'(timeout) > 1)
                check("strobe_overlap", {28'd0, cnp_start, vnp_start, dec_start, timeout}, 32'd0);
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_result: got a finished decode, expected none");
                end else begin
                    check("result", pack(to_seen, converged, failed, rate_q, iter_num,
                                         c_cnp, c_vnp, c_dec), exp_q.pop_front());
                end
                c_cnp = 0; c_vnp = 0; c_dec = 0; to_seen = 0;
            end
            prev_busy = busy;
        end
    end

    // driver tasks
    task automatic wait_cnp(output bit ok);
        ok = 0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (cnp_start) begin ok = 1; return; end
            tick();
        end
        tests++;
        errors++;
        $display("FAIL wait_cnp_start: got no strobe in %0d cycles, expected cnp_start", WAIT_MAX);
    endtask

    task automatic wait_vnp_dec(output bit ok, output bit is_vnp);
        ok = 0;
        is_vnp = 0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            if (vnp_start || dec_start) begin ok = 1; is_vnp = vnp_start; return; end
            tick();
        end
        tests++;
        errors++;
        $display("FAIL wait_vnp_dec: got no strobe in %0d cycles, expected vnp_start or dec_start", WAIT_MAX);
    endtask

    task automatic start_decode(input logic [7:0] mi, input logic [1:0] rt, input bit noise);
        max_iter = mi; rate = rt; start = 1'b1; tick(); start = 1'b0;
        if (noise) begin
            // unexpected done pulses and a second start while in INIT
            cnp_done = 1; vnp_done = 1; dec_done = 1; start = 1; max_iter = 8'd0; rate = ~rt;
            tick();
            cnp_done = 0; vnp_done = 0; dec_done = 0; start = 0; max_iter = mi; rate = rt;
        end
        init_done = 1'b1; tick(); init_done = 1'b0;
    endtask

    // one CNP pass: optional bad syndrome (before or with cnp_done), then cnp_done
    task automatic cnp_pass(input bit bad, input logic [17:0] syn, input bit coinc);
        if (bad) begin
            syn_vld = 1'b1; syn_word = syn;
            if (!coinc) begin tick(); syn_vld = 1'b0; syn_word = '0; end
        end
        cnp_done = 1'b1; tick();
        cnp_done = 1'b0; syn_vld = 1'b0; syn_word = '0;
    endtask

    typedef struct {
        logic [7:0]  mi;
        logic [1:0]  rt;
        int          nbad;
        logic [17:0] syn;
        bit          coinc;
        bit          noise;
        logic [31:0] exp;
    } vec_t;

    task automatic run_decode(input vec_t v);
        bit ok, is_vnp;
        exp_q.push_back(v.exp);
        start_decode(v.mi, v.rt, v.noise);
        for (int pass = 0; pass < 64; pass++) begin
            wait_cnp(ok);
            if (!ok) return;
            if (v.noise && pass == 0) begin
                vnp_done = 1; dec_done = 1; start = 1; tick();
                vnp_done = 0; dec_done = 0; start = 0;
            end
            cnp_pass(pass < v.nbad, v.syn, v.coinc);
            wait_vnp_dec(ok, is_vnp);
            if (!ok) return;
            if (!is_vnp) begin
                dec_done = 1'b1; tick(); dec_done = 1'b0;
                break;
            end
            vnp_done = 1'b1; tick(); vnp_done = 1'b0;
        end
        repeat (3) tick();
        check("status_hold", {30'd0, converged, failed}, {30'd0, v.exp[29], v.exp[28]});
    endtask

    vec_t vecs[7];

    initial begin
        bit ok, is_vnp;
        //           mi      rt  nbad  syn        coinc noise  expected result
        vecs[0] = '{8'd5,   2'd1, 0,  18'h00000, 0, 0, pack(0, 1, 0, 2'd1, 8'd0, 1, 0, 1)};
        vecs[1] = '{8'd3,   2'd2, 99, 18'h00001, 0, 0, pack(0, 0, 1, 2'd2, 8'd3, 4, 3, 1)};
        vecs[2] = '{8'd0,   2'd3, 99, 18'h00003, 0, 0, pack(0, 0, 1, 2'd3, 8'd0, 1, 0, 1)};
        vecs[3] = '{8'd2,   2'd0, 1,  18'h20000, 1, 0, pack(0, 1, 0, 2'd0, 8'd1, 2, 1, 1)};
        vecs[4] = '{8'd2,   2'd1, 2,  18'h00100, 0, 1, pack(0, 1, 0, 2'd1, 8'd2, 3, 2, 1)};
        vecs[5] = '{8'd255, 2'd2, 4,  18'h3ffff, 0, 0, pack(0, 1, 0, 2'd2, 8'd4, 5, 4, 1)};
        vecs[6] = '{8'd1,   2'd3, 5,  18'h00010, 1, 1, pack(0, 0, 1, 2'd3, 8'd1, 2, 1, 1)};

        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_state");
        reset = 1'b0;
        tick();
        check_idle("idle_after_reset");

        for (int i = 0; i < 7; i++) run_decode(vecs[i]);

        // reset while in VNP with iter_num = 2
        start_decode(8'd5, 2'd2, 0);
        for (int pass = 0; pass < 2; pass++) begin
            wait_cnp(ok);
            cnp_pass(1, 18'h00001, 1);
            wait_vnp_dec(ok, is_vnp);
            if (pass == 0) begin vnp_done = 1'b1; tick(); vnp_done = 1'b0; end
        end
        check("iter_before_reset", {31'd0, vnp_start} | (32'(iter_num) << 1), 32'd5);
        #1 reset = 1'b1;
        #1 check_idle("reset_mid_vnp");
        tick();
        reset = 1'b0;
        tick();
        check_idle("idle_after_mid_reset");
        run_decode(vecs[0]);

`ifdef LDPC_ITER_WDOG_EN
        begin
            int n;
            exp_q.push_back(pack(1, 0, 1, 2'd1, 8'd1, 1, 1, 0));
            start_decode(8'd4, 2'd1, 0);
            wait_cnp(ok);
            cnp_pass(1, 18'h00001, 1);
            wait_vnp_dec(ok, is_vnp);
            n = 0;
            while (!timeout && n < 200) begin tick(); n++; end
            check("wdog_latency", n, 100);
            check("wdog_status", {30'd0, busy, failed}, 32'd1);
            tick();
            check("wdog_pulse_width", {31'd0, timeout}, 32'd0);
        end
`endif

        repeat (4) tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
